// File: rtl/setup_packet_loader.sv
// Packet-to-setup-bus replayer: takes a header plus 1-8 payload bytes and strobes
// each byte onto the tile's setup bus with one sync pulse followed by a low gap.
module setup_packet_loader #(
   parameter int unsigned GAP_CYCLES = 1  // legal range 1-15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] setup_data,
   output logic [2:0] setup_control,
   output logic       setup_sync,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HIGH,
      S_LOW
   } state_t;

   localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

   state_t     state_q;
   logic [3:0] remaining_q;
   logic [3:0] gap_q;
   logic       in_ready_q;
   logic [7:0] setup_data_q;
   logic [2:0] setup_control_q;
   logic       setup_sync_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;

   logic xfer;
   logic hdr_ok;

   assign xfer = in_valid & in_ready_q;

   // Code 101 is the tile's streaming code and 111 is undefined; neither may
   // ever reach setup_control, so both are rejected at the header.
   assign hdr_ok = (in_data[7:6] == 2'b00) &&
                   (in_data[2:0] != 3'b101) &&
                   (in_data[2:0] != 3'b111);

   // NOTE: all state and outputs update with non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         remaining_q     <= 4'd0;
         gap_q           <= 4'd0;
         in_ready_q      <= 1'b1;
         setup_data_q    <= 8'h00;
         setup_control_q <= 3'b000;
         setup_sync_q    <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  if (hdr_ok) begin
                     setup_control_q <= in_data[2:0];
                     remaining_q     <= 4'(in_data[5:3]) + 4'd1;
                     busy_q          <= 1'b1;
                     state_q         <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  setup_data_q <= in_data;
                  remaining_q  <= remaining_q - 4'd1;
                  setup_sync_q <= 1'b1;
                  in_ready_q   <= 1'b0;
                  state_q      <= S_HIGH;
               end
            end
            S_HIGH: begin
               setup_sync_q <= 1'b0;
               gap_q        <= GAP_INIT;
               state_q      <= S_LOW;
            end
            S_LOW: begin
               if (gap_q <= 4'd1) begin
                  in_ready_q <= 1'b1;
                  if (remaining_q != 4'd0) begin
                     state_q <= S_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign setup_data    = setup_data_q;
   assign setup_control = setup_control_q;
   assign setup_sync    = setup_sync_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_setup_packet_loader.sv
// Two loaders (gap 1 and gap 3) driven from byte queues and checked every cycle
// against a timeline model of when each output must change.
module tb_setup_packet_loader;

   localparam int NL  = 2;
   localparam int G0  = 1;
   localparam int G1  = 3;
   localparam int BIG = 32'h7fff_ffff;

   typedef struct packed {
      logic [7:0] b;
      logic [3:0] dly;
   } item_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data       [NL];
   logic       in_valid      [NL];
   logic       in_ready      [NL];
   logic [7:0] setup_data    [NL];
   logic [2:0] setup_control [NL];
   logic       setup_sync    [NL];
   logic       busy          [NL];
   logic       done          [NL];
   logic       err           [NL];

   initial forever #5 clk = ~clk;

   setup_packet_loader #(.GAP_CYCLES(G0)) u_dut0 (
      .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .setup_data(setup_data[0]), .setup_control(setup_control[0]),
      .setup_sync(setup_sync[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   setup_packet_loader #(.GAP_CYCLES(G1)) u_dut1 (
      .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .setup_data(setup_data[1]), .setup_control(setup_control[1]),
      .setup_sync(setup_sync[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   // Timeline model: each output is derived from the cycle numbers at which
   // events were scheduled when bytes were accepted.
   int         free_at    [NL];
   int         sync_at    [NL];
   int         done_at    [NL];
   int         err_at     [NL];
   int         busy_from  [NL];
   int         busy_until [NL];
   int         left       [NL];
   logic [7:0] m_data     [NL];
   logic [2:0] m_ctrl     [NL];
   bit         mvalid     [NL];

   item_t      q        [NL][$];
   int         sync_cyc [NL][$];
   logic [7:0] sync_dat [NL][$];
   int         done_cyc [NL][$];
   int         err_cyc  [NL][$];
   int         hdr_cyc  [NL][$];

   int cyc;
   bit rst_req;
   int n_pass;
   int n_total;

   function automatic int gap_of(int l);
      return (l == 0) ? G0 : G1;
   endfunction

   function automatic bit hdr_ok(logic [7:0] b);
      return (b[7:6] == 2'b00) && (b[2:0] != 3'b101) && (b[2:0] != 3'b111);
   endfunction

   function automatic bit lane_idle(int l);
      return (q[l].size() == 0) && (left[l] == 0) && (cyc > free_at[l]) && (cyc > err_at[l]);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic compare(int l);
      if (!mvalid[l]) return;
      check($sformatf("l%0d_in_ready", l), 32'(in_ready[l]), 32'(cyc >= free_at[l]));
      check($sformatf("l%0d_data", l), 32'(setup_data[l]), 32'(m_data[l]));
      check($sformatf("l%0d_control", l), 32'(setup_control[l]), 32'(m_ctrl[l]));
      check($sformatf("l%0d_sync", l), 32'(setup_sync[l]), 32'(cyc == sync_at[l]));
      check($sformatf("l%0d_busy", l), 32'(busy[l]),
            32'((cyc >= busy_from[l]) && (cyc < busy_until[l])));
      check($sformatf("l%0d_done", l), 32'(done[l]), 32'(cyc == done_at[l]));
      check($sformatf("l%0d_err", l), 32'(err[l]), 32'(cyc == err_at[l]));
      if (setup_sync[l] === 1'b1) begin
         sync_cyc[l].push_back(cyc);
         sync_dat[l].push_back(setup_data[l]);
      end
      if (done[l] === 1'b1) done_cyc[l].push_back(cyc);
      if (err[l] === 1'b1) err_cyc[l].push_back(cyc);
   endtask

   task automatic drive(int l);
      item_t      h;
      bit         v;
      logic [7:0] b;
      if (reset) begin
         m_data[l] = 8'h00;  m_ctrl[l] = 3'b000;  left[l] = 0;
         sync_at[l] = -1;  done_at[l] = -1;  err_at[l] = -1;  free_at[l] = 0;
         busy_from[l] = BIG;  busy_until[l] = BIG;  mvalid[l] = 1'b1;
         q[l].delete();
         in_valid[l] = 1'b0;
         in_data[l]  = 8'h00;
         return;
      end
      v = 1'b0;
      b = 8'($urandom);
      if (q[l].size() > 0) begin
         h = q[l][0];
         if (h.dly != 4'd0) begin
            h.dly = h.dly - 4'd1;
            q[l][0] = h;
         end else begin
            v = 1'b1;
            b = h.b;
         end
      end
      in_valid[l] = v;
      in_data[l]  = b;
      if (v && mvalid[l] && (cyc >= free_at[l])) begin
         void'(q[l].pop_front());
         if (left[l] == 0) begin
            hdr_cyc[l].push_back(cyc);
            if (hdr_ok(b)) begin
               m_ctrl[l]     = b[2:0];
               left[l]       = int'(b[5:3]) + 1;
               busy_from[l]  = cyc + 1;
               busy_until[l] = BIG;
            end else begin
               err_at[l] = cyc + 1;
            end
         end else begin
            m_data[l]  = b;
            sync_at[l] = cyc + 1;
            free_at[l] = cyc + 2 + gap_of(l);
            left[l]--;
            if (left[l] == 0) begin
               done_at[l]    = cyc + 2 + gap_of(l);
               busy_until[l] = cyc + 2 + gap_of(l);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int l = 0; l < NL; l++) compare(l);
      reset = rst_req;
      for (int l = 0; l < NL; l++) drive(l);
   endtask

   task automatic run_idle(int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(lane_idle(0) && lane_idle(1)) && n < budget);
      check("drain", 32'(lane_idle(0) && lane_idle(1)), 32'd1);
   endtask

   task automatic push(int l, logic [7:0] b, int dly = 0);
      item_t it;
      it.b   = b;
      it.dly = 4'(dly);
      q[l].push_back(it);
   endtask

   task automatic clear_logs();
      for (int l = 0; l < NL; l++) begin
         sync_cyc[l].delete();  sync_dat[l].delete();
         done_cyc[l].delete();  err_cyc[l].delete();  hdr_cyc[l].delete();
      end
   endtask

   function automatic int first_hdr(int l);
      return (hdr_cyc[l].size() > 0) ? hdr_cyc[l][0] : -1000;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_a [4];
      logic [7:0] hb;
      int         h0;
      int         n;
      int         k;

      n_pass = 0;  n_total = 0;  cyc = 0;  rst_req = 1'b0;
      for (int l = 0; l < NL; l++) begin
         in_valid[l] = 1'b0;  in_data[l] = 8'h00;  mvalid[l] = 1'b0;  left[l] = 0;
      end

      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready[0]), 32'd1);
      check("rst_control", 32'(setup_control[0]), 32'd0);
      check("rst_data", 32'(setup_data[0]), 32'd0);
      check("rst_sync", 32'(setup_sync[0]), 32'd0);
      check("rst_busy", 32'(busy[0]), 32'd0);
      check("rst_done", 32'(done[0]), 32'd0);
      check("rst_err", 32'(err[0]), 32'd0);

      // 4-byte packet at gap 1 on lane 0, 2-byte packet at gap 3 on lane 1
      clear_logs();
      exp_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      push(0, 8'h19);
      foreach (exp_a[i]) push(0, exp_a[i]);
      push(1, 8'h0B);  push(1, 8'hF0);  push(1, 8'h0F);
      run_idle(200);
      h0 = first_hdr(0);
      check("a_sync_count", 32'(sync_cyc[0].size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < sync_cyc[0].size()) begin
            check($sformatf("a_sync%0d_cycle", i), 32'(sync_cyc[0][i] - h0), 32'(2 + 3 * i));
            check($sformatf("a_sync%0d_data", i), 32'(sync_dat[0][i]), 32'(exp_a[i]));
         end
      end
      check("a_done_count", 32'(done_cyc[0].size()), 32'd1);
      if (done_cyc[0].size() > 0) check("a_done_latency", 32'(done_cyc[0][0] - h0), 32'd13);
      check("a_control", 32'(setup_control[0]), 32'd1);
      check("g3_sync_count", 32'(sync_cyc[1].size()), 32'd2);
      if (sync_cyc[1].size() == 2) begin
         check("g3_spacing", 32'(sync_cyc[1][1] - sync_cyc[1][0]), 32'd5);
         check("g3_data0", 32'(sync_dat[1][0]), 32'hF0);
         check("g3_data1", 32'(sync_dat[1][1]), 32'h0F);
      end
      check("g3_control", 32'(setup_control[1]), 32'd3);

      // rejected headers
      clear_logs();
      push(0, 8'h05);
      push(0, 8'h47);
      run_idle(50);
      check("b_err_count", 32'(err_cyc[0].size()), 32'd2);
      check("b_sync_count", 32'(sync_cyc[0].size()), 32'd0);
      check("b_control", 32'(setup_control[0]), 32'd1);

      // payload arriving late
      clear_logs();
      push(0, 8'h02);
      push(0, 8'h07, 5);
      run_idle(50);
      check("c_sync_count", 32'(sync_cyc[0].size()), 32'd1);
      if (sync_cyc[0].size() > 0) begin
         check("c_sync_cycle", 32'(sync_cyc[0][0] - first_hdr(0)), 32'd7);
         check("c_data", 32'(sync_dat[0][0]), 32'h07);
      end
      check("c_control", 32'(setup_control[0]), 32'd2);
      check("c_done_count", 32'(done_cyc[0].size()), 32'd1);

      // reset during the low gap after byte 2 of a 4-byte packet
      clear_logs();
      push(0, 8'h1C);  push(0, 8'h11);  push(0, 8'h22);  push(0, 8'h33);  push(0, 8'h44);
      n = 0;
      while (sync_cyc[0].size() < 2 && n < 100) begin
         tick();
         n++;
      end
      check("d_reached_byte2", 32'(sync_cyc[0].size()), 32'd2);
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick();
      check("d_rst_control", 32'(setup_control[0]), 32'd0);
      check("d_rst_data", 32'(setup_data[0]), 32'd0);
      check("d_rst_busy", 32'(busy[0]), 32'd0);
      check("d_rst_in_ready", 32'(in_ready[0]), 32'd1);
      clear_logs();
      push(0, 8'h00);
      push(0, 8'h5A);
      run_idle(50);
      check("d_sync_count", 32'(sync_cyc[0].size()), 32'd1);
      if (sync_cyc[0].size() > 0) check("d_data", 32'(sync_dat[0][0]), 32'h5A);
      check("d_control", 32'(setup_control[0]), 32'd0);

      // random packets with random headers and input stalls
      for (int p = 0; p < 40; p++) begin
         for (int l = 0; l < NL; l++) begin
            if ($urandom_range(0, 4) == 0) begin
               hb = 8'($urandom);
            end else begin
               k  = int'($urandom_range(0, 5));
               hb = {2'b00, 3'($urandom_range(0, 7)), 3'((k < 5) ? k : 6)};
            end
            push(l, hb, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
            if (hdr_ok(hb)) begin
               for (int i = 0; i <= int'(hb[5:3]); i++)
                  push(l, 8'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            end
         end
      end
      run_idle(20000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/setup_packet_loader.md
Name: setup_packet_loader

Overview:
- Upstream feeder for the LIF/PWM neuron tile's setup bus.
- Accepts a byte-wide valid/ready packet stream: one header byte, then 1-8 payload bytes.
- Replays each payload byte onto setup_data/setup_control/setup_sync with a clean rising edge per byte, at a rate the tile's sync edge detector can follow.
- Keeps the forbidden streaming code (3'b101) off the bus, so config loads never corrupt the input shift register.

Parameters:
- GAP_CYCLES, 1, number of cycles setup_sync is held low after each high pulse; legal range 1-15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data  in  8  packet byte (header or payload)
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid & in_ready
- setup_data  out  8  byte presented to the tile's data input
- setup_control  out  3  target register code to the tile
- setup_sync  out  1  load strobe; the tile acts on its rising edge
- busy  out  1  a packet is in progress
- done  out  1  one-cycle pulse when a packet has been fully replayed
- err  out  1  one-cycle pulse when a header is rejected

Behaviour:
- All outputs are registered.
- Reset values: setup_data=8'h00, setup_control=3'b000, setup_sync=0, busy=0, done=0, err=0, in_ready=1 (state IDLE). Reset wins over every other event.
- Header byte format:
  - [2:0] = code.
  - [5:3] = len-1, so len = 1..8.
  - [7:6] must be 2'b00.
- Header validity:
  - Accepted codes: 000, 001, 010, 011, 100, 110.
  - Codes 101 and 111 are rejected.
  - A header with [7:6] != 00 is rejected.
- States: IDLE, LOAD, HIGH, LOW.
- IDLE:
  - in_ready=1.
  - Valid header accepted: latch code into setup_control, remaining=len, go to LOAD, busy=1 from the next cycle.
  - Invalid header: byte is consumed, err=1 for the next cycle, stay in IDLE, setup_control unchanged.
- LOAD:
  - in_ready=1, setup_sync=0.
  - On transfer: setup_data<=in_data, remaining<=remaining-1, go to HIGH.
  - Without in_valid: wait indefinitely; all outputs hold.
- HIGH:
  - in_ready=0, setup_sync=1 for exactly one cycle.
  - Then go to LOW with gap counter=GAP_CYCLES.
- LOW:
  - in_ready=0, setup_sync=0.
  - Counter decrements each cycle.
  - On expiry: go to LOAD if remaining>0; otherwise go to IDLE and pulse done=1, busy=0 in that first IDLE cycle.
- Stability:
  - setup_data holds from the HIGH cycle through the end of LOW.
  - setup_control holds for the whole packet and retains its last value while idle.
  - setup_control never shows 3'b101 at any time, including after reset.
- Throughput with in_valid held high: 2+GAP_CYCLES cycles per payload byte. With GAP=1, a 4-byte packet takes 1 header cycle + 12 cycles.
- Headers are accepted only in IDLE. A header can be accepted in the same cycle done is high; back-to-back packets are allowed.
- Counter widths:
  - remaining: 4 bits.
  - gap counter: 4 bits.
- Reset mid-packet (any state): next cycle is IDLE with the reset values; a partially loaded target is left as-is in the tile.

Test Plan:
- Reset pulse -> next cycle: setup_sync=0, setup_control=000, setup_data=00, in_ready=1, busy=0, done=0, err=0.
- GAP=1, stream 0x19, AA, BB, CC, DD with in_valid always high:
  - 4 single-cycle sync pulses spaced 3 cycles apart.
  - setup_data = AA, BB, CC, DD at each pulse.
  - setup_control = 001 throughout.
  - done pulses exactly once, 13 cycles after the header transfer.
- Header 0x05 (code 101) and header 0x47 ([7:6]=01):
  - err pulses once for each header.
  - No sync pulse; setup_control stays at its previous value (never 101); busy stays 0.
- Header 0x02, then payload 0x07 presented 5 cycles late:
  - Loader waits in LOAD with in_ready=1, sync=0.
  - Then one pulse with data 07, control 010, done.
- GAP=3, header 0x0B (code 011, len 2), payload F0, 0F:
  - Each sync pulse is followed by exactly 3 low cycles.
  - in_ready=0 during HIGH/LOW.
- Reset asserted during LOW of byte 2 of a 4-byte packet:
  - Next cycle is in IDLE with reset values.
  - A fresh header 0x00 + 0x5A then produces one pulse with data 5A, control 000.
